// File: rtl/mmio_device_port.sv
// Bus-facing write FIFO and status register for a memory-mapped peripheral.
// Define MMIO_DEVICE_PORT_IRQ_EN to build the drain/overflow interrupt; otherwise irq is tied low.
module mmio_device_port #(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] DATA_ADDR   = 16'hFFFE,
  parameter logic [15:0] STATUS_ADDR = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bus_valid,
  input  logic        rw,
  input  logic [31:0] address_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        read_valid,
  output logic [31:0] dev_data,
  output logic        dev_valid,
  input  logic        dev_ready,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_NONEMPTY = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic hit_data, hit_stat, full, not_empty, push, pop, ovf_set;
  logic [31:0] status_word;
  logic unused_addr;

  assign hit_data  = bus_valid &  rw & (address_in[15:0] == DATA_ADDR);
  assign hit_stat  = bus_valid & ~rw & (address_in[15:0] == STATUS_ADDR);
  assign unused_addr = ^address_in[31:16];

  assign full      = (state == ST_FULL);
  assign not_empty = (state != ST_EMPTY);
  assign dev_valid = not_empty;

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign pop     = dev_valid & dev_ready;
  assign push    = hit_data & (~full | pop);
  assign ovf_set = hit_data & full & ~pop;

  assign dev_data = not_empty ? mem[rd_ptr] : '0;

  assign status_word = {19'b0, 5'(count), 5'b0, overflow, full, not_empty};

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY:    if (push) state_nxt = ST_NONEMPTY;
      ST_NONEMPTY: begin
        if (push && !pop && count == CW'(DEPTH - 1)) state_nxt = ST_FULL;
        else if (pop && !push && count == CW'(1))    state_nxt = ST_EMPTY;
      end
      ST_FULL:     if (pop && !push) state_nxt = ST_NONEMPTY;
      default:     state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      data_out   <= '0;
      read_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (ovf_set)       overflow <= 1'b1;
      else if (hit_stat) overflow <= 1'b0;
      read_valid <= hit_stat;
      if (hit_stat) data_out <= status_word;
    end
  end

  // NOTE: storage has no reset; stale words are never visible because dev_data is gated by state.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data_in;
  end

`ifdef MMIO_DEVICE_PORT_IRQ_EN
  logic drained;
  logic irq_q;

  assign drained = pop & ~push & (state == ST_NONEMPTY) & (count == CW'(1));
  assign irq     = irq_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                irq_q <= 1'b0;
    else if (drained || ovf_set) irq_q <= 1'b1;
    else if (hit_stat)           irq_q <= 1'b0;
  end
`else
  assign irq = 1'b0;
`endif

endmodule
